// File: rtl/vend_pkg.sv
// vend_pkg: shared types and constants for the vend_controller sale sequencer.
//   - state_t        : sequencer states
//   - COIN_*         : coin codes driven on coin_code
//   - coin_value()   : cents for a coin code (0 for unused codes)
//   - item_price()   : fixed price table, item 7 is not for sale (price 0)
package vend_pkg;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_CHECK  = 3'd1,
    S_VEND   = 3'd2,
    S_CHANGE = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  localparam int NUM_COINS = 5;

  // Coin code n (1..5) maps to availability/inventory slot n-1.
  localparam logic [2:0] COIN_NONE = 3'b000;
  localparam logic [2:0] COIN_5    = 3'b001;
  localparam logic [2:0] COIN_10   = 3'b010;
  localparam logic [2:0] COIN_25   = 3'b011;
  localparam logic [2:0] COIN_50   = 3'b100;
  localparam logic [2:0] COIN_100  = 3'b101;

  localparam logic [8:0] VAL_5   = 9'd5;
  localparam logic [8:0] VAL_10  = 9'd10;
  localparam logic [8:0] VAL_25  = 9'd25;
  localparam logic [8:0] VAL_50  = 9'd50;
  localparam logic [8:0] VAL_100 = 9'd100;

  function automatic logic [8:0] coin_value(input logic [2:0] code);
    case (code)
      COIN_5:   return VAL_5;
      COIN_10:  return VAL_10;
      COIN_25:  return VAL_25;
      COIN_50:  return VAL_50;
      COIN_100: return VAL_100;
      default:  return 9'd0;
    endcase
  endfunction

  function automatic logic [8:0] item_price(input logic [2:0] item);
    case (item)
      3'd0:    return 9'd50;
      3'd1:    return 9'd65;
      3'd2:    return 9'd75;
      3'd3:    return 9'd100;
      3'd4:    return 9'd125;
      3'd5:    return 9'd150;
      3'd6:    return 9'd200;
      default: return 9'd0;
    endcase
  endfunction

endpackage

// File: rtl/vend_if.sv
// vend_if: handshake bundle between the sale sequencer and its neighbours.
//   selection : sel_valid/sel_item in, sel_ready out
//   dispense  : vend_valid/vend_item out, vend_ready in
//   change    : coin_valid/coin_code out, coin_ready in
// master = the controller, slave = selector panel / dispenser / coin ejector.
interface vend_if;
  logic       sel_valid;
  logic [2:0] sel_item;
  logic       sel_ready;
  logic       vend_valid;
  logic [2:0] vend_item;
  logic       vend_ready;
  logic       coin_valid;
  logic [2:0] coin_code;
  logic       coin_ready;

  modport master (
    input  sel_valid, sel_item, vend_ready, coin_ready,
    output sel_ready, vend_valid, vend_item, coin_valid, coin_code
  );

  modport slave (
    output sel_valid, sel_item, vend_ready, coin_ready,
    input  sel_ready, vend_valid, vend_item, coin_valid, coin_code
  );
endinterface

// File: rtl/vend_change_selector.sv
// vend_change_selector: combinational greedy coin picker.
//   remaining : cents still owed
//   avail     : bit n set when coin code n+1 may be paid
//   code/value: largest available coin not exceeding remaining
//   none      : no such coin (remaining 0, a 1-4 cent residue, or supply out)
module vend_change_selector
  import vend_pkg::*;
(
  input  logic [8:0]           remaining,
  input  logic [NUM_COINS-1:0] avail,
  output logic [2:0]           code,
  output logic [8:0]           value,
  output logic                 none
);

  // Codes increase with value, so scanning from the top slot down is greedy.
  always_comb begin
    none  = 1'b1;
    code  = COIN_NONE;
    value = '0;
    for (int i = NUM_COINS - 1; i >= 0; i--) begin
      if (none && avail[i] && (coin_value(3'(i + 1)) <= remaining)) begin
        none  = 1'b0;
        code  = 3'(i + 1);
        value = coin_value(3'(i + 1));
      end
    end
  end

endmodule

// File: rtl/vend_controller.sv
// vend_controller: sale sequencer behind the coin payment stage.
// Snapshots credit on a selection, checks it against the price table, issues
// a vend request, then pays change (or a full refund) one coin at a time.
//   clk, reset      : clock, asynchronous active-high reset
//   credit          : accumulated credit (cents) from the payment stage
//   accept_en       : upstream accumulation enable (high only in IDLE)
//   cancel          : refund request, honoured in IDLE with nonzero credit
//   err_credit      : one-cycle pulse, sale rejected
//   change_short    : one-cycle pulse, change could not be completed
//   busy            : high outside IDLE
//   bus             : selection / dispense / coin handshakes (vend_if.master)
// Build option VEND_CHANGE_INVENTORY_EN adds inv_load/inv_code/inv_count and
// a per-denomination coin count that gates the greedy selection.
module vend_controller
  import vend_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [8:0] credit,
  output logic       accept_en,
  input  logic       cancel,
  output logic       err_credit,
  output logic       change_short,
  output logic       busy,
  vend_if.master     bus
`ifdef VEND_CHANGE_INVENTORY_EN
  ,
  input  logic       inv_load,
  input  logic [2:0] inv_code,
  input  logic [7:0] inv_count
`endif
);

  state_t     state, state_nxt;
  logic [8:0] rem_q, rem_nxt;
  logic [2:0] item_q, item_nxt;
  logic       err_nxt, short_nxt;

  logic [NUM_COINS-1:0] avail;
  logic [2:0]           sel_code;
  logic [8:0]           sel_value;
  logic                 sel_none;
  logic                 coin_offer;

  vend_change_selector u_sel (
    .remaining (rem_q),
    .avail     (avail),
    .code      (sel_code),
    .value     (sel_value),
    .none      (sel_none)
  );

  // A coin is offered only from registered state, so coin_valid/coin_code
  // have no path from any input and hold steady while the ejector stalls.
  assign coin_offer = (state == S_CHANGE) && (rem_q != '0) && !sel_none;

`ifdef VEND_CHANGE_INVENTORY_EN
  logic [NUM_COINS-1:0][7:0] inv_cnt;
  logic                      coin_hs;

  assign coin_hs = coin_offer && bus.coin_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      inv_cnt <= '0;
    end else if ((state == S_IDLE) && inv_load &&
                 (inv_code >= COIN_5) && (inv_code <= COIN_100)) begin
      inv_cnt[inv_code - 3'd1] <= inv_count;
    end else if (coin_hs) begin
      inv_cnt[sel_code - 3'd1] <= inv_cnt[sel_code - 3'd1] - 8'd1;
    end
  end

  always_comb begin
    avail = '0;
    for (int i = 0; i < NUM_COINS; i++) avail[i] = (inv_cnt[i] != 8'd0);
  end
`else
  assign avail = '1;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= S_IDLE;
      rem_q        <= '0;
      item_q       <= '0;
      err_credit   <= 1'b0;
      change_short <= 1'b0;
    end else begin
      state        <= state_nxt;
      rem_q        <= rem_nxt;
      item_q       <= item_nxt;
      err_credit   <= err_nxt;
      change_short <= short_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    rem_nxt   = rem_q;
    item_nxt  = item_q;
    err_nxt   = 1'b0;
    short_nxt = 1'b0;
    case (state)
      S_IDLE: begin
        if (cancel && (credit != '0)) begin
          rem_nxt   = credit;
          state_nxt = S_CHANGE;
        end else if (bus.sel_valid) begin
          // rem_q holds the credit snapshot until CHECK prices it.
          item_nxt  = bus.sel_item;
          rem_nxt   = credit;
          state_nxt = S_CHECK;
        end
      end
      S_CHECK: begin
        if ((item_price(item_q) == '0) || (rem_q < item_price(item_q))) begin
          err_nxt   = 1'b1;
          state_nxt = S_CHANGE;
        end else begin
          rem_nxt   = rem_q - item_price(item_q);
          state_nxt = S_VEND;
        end
      end
      S_VEND: begin
        if (bus.vend_ready) state_nxt = (rem_q == '0) ? S_DONE : S_CHANGE;
      end
      S_CHANGE: begin
        if (rem_q == '0) begin
          state_nxt = S_DONE;
        end else if (sel_none) begin
          short_nxt = 1'b1;
          state_nxt = S_DONE;
        end else if (bus.coin_ready) begin
          rem_nxt = rem_q - sel_value;
          if (rem_q == sel_value) state_nxt = S_DONE;
        end
      end
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  assign accept_en      = (state == S_IDLE);
  assign bus.sel_ready  = (state == S_IDLE);
  assign busy           = (state != S_IDLE);
  assign bus.vend_valid = (state == S_VEND);
  assign bus.vend_item  = (state == S_VEND) ? item_q : 3'd0;
  assign bus.coin_valid = coin_offer;
  assign bus.coin_code  = coin_offer ? sel_code : COIN_NONE;

endmodule

// File: tb/tb_vend_controller.sv
// Scoreboard bench for vend_controller: stimulus pushes expected events
// (vend, err_credit, coin, change_short) and a negedge monitor pops and
// compares each event the DUT produces.
module tb_vend_controller;

  localparam int K_VEND  = 0;
  localparam int K_ERR   = 1;
  localparam int K_COIN  = 2;
  localparam int K_SHORT = 3;

  typedef struct {
    int kind;
    int val;
  } ev_t;

  logic       clk = 1'b0;
  logic       reset;
  logic [8:0] credit;
  logic       accept_en, cancel, err_credit, change_short, busy;
`ifdef VEND_CHANGE_INVENTORY_EN
  logic       inv_load;
  logic [2:0] inv_code;
  logic [7:0] inv_count;
`endif

  vend_if bus ();

  vend_controller dut (
    .clk          (clk),
    .reset        (reset),
    .credit       (credit),
    .accept_en    (accept_en),
    .cancel       (cancel),
    .err_credit   (err_credit),
    .change_short (change_short),
    .busy         (busy),
    .bus          (bus)
`ifdef VEND_CHANGE_INVENTORY_EN
    ,
    .inv_load     (inv_load),
    .inv_code     (inv_code),
    .inv_count    (inv_count)
`endif
  );

  always #5 clk = ~clk;

  ev_t exp_q[$];
  int  n_cmp = 0;
  int  n_err = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic push(input int k, input int v);
    ev_t e;
    e.kind = k;
    e.val  = v;
    exp_q.push_back(e);
  endtask

  task automatic observe(input int k, input int v);
    ev_t e;
    if (exp_q.size() == 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL unexpected_event: got kind %0d val %0d, expected no event", k, v);
    end else begin
      e = exp_q.pop_front();
      chk("event_kind", k, e.kind);
      chk("event_val", v, e.val);
    end
  endtask

  // Inputs change only at posedge+1, so a negedge sample of valid&ready is
  // exactly the handshake taken at the next posedge.
  always @(negedge clk) begin
    if (!reset) begin
      if (bus.vend_valid && bus.vend_ready) observe(K_VEND, int'(bus.vend_item));
      if (err_credit)                       observe(K_ERR, 0);
      if (bus.coin_valid && bus.coin_ready) observe(K_COIN, int'(bus.coin_code));
      if (change_short)                     observe(K_SHORT, 0);
    end
  end

  task automatic drive_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic select(input int cr, input int item);
    drive_edge();
    credit        = 9'(cr);
    bus.sel_item  = 3'(item);
    bus.sel_valid = 1'b1;
    drive_edge();
    bus.sel_valid = 1'b0;
    credit        = '0;  // upstream clears while accept_en is low
  endtask

  // Checks accept_en stays low for the whole sale, then that every
  // expected event was seen.
  task automatic wait_idle(input string name);
    int cnt = 0;
    @(negedge clk);
    while (busy && cnt < 100) begin
      chk({name, "_accept_en_low"}, accept_en, 0);
      @(negedge clk);
      cnt++;
    end
    chk({name, "_idle_reached"}, busy, 0);
    chk({name, "_accept_en_idle"}, accept_en, 1);
    chk({name, "_sb_empty"}, exp_q.size(), 0);
    exp_q.delete();
  endtask

  initial begin
    reset          = 1'b1;
    credit         = '0;
    cancel         = 1'b0;
    bus.sel_valid  = 1'b0;
    bus.sel_item   = '0;
    bus.vend_ready = 1'b1;
    bus.coin_ready = 1'b1;
`ifdef VEND_CHANGE_INVENTORY_EN
    inv_load  = 1'b0;
    inv_code  = '0;
    inv_count = '0;
`endif

    // Reset values
    repeat (2) @(negedge clk);
    chk("rst_sel_ready", bus.sel_ready, 1);
    chk("rst_accept_en", accept_en, 1);
    chk("rst_vend_valid", bus.vend_valid, 0);
    chk("rst_coin_valid", bus.coin_valid, 0);
    chk("rst_err_credit", err_credit, 0);
    chk("rst_change_short", change_short, 0);
    chk("rst_busy", busy, 0);
    chk("rst_vend_item", bus.vend_item, 0);
    chk("rst_coin_code", bus.coin_code, 0);
    drive_edge();
    reset = 1'b0;

`ifdef VEND_CHANGE_INVENTORY_EN
    // Plenty of every coin so the unlimited-supply tests still hold.
    for (int c = 1; c <= 5; c++) begin
      drive_edge();
      inv_load  = 1'b1;
      inv_code  = 3'(c);
      inv_count = 8'd255;
    end
    drive_edge();
    inv_load = 1'b0;
`endif

    // Credit 100, item 1 (65): change 35 = 25 + 10
    push(K_VEND, 1); push(K_COIN, 3); push(K_COIN, 2);
    select(100, 1);
    wait_idle("t1");

    // Credit 50, item 3 (100): rejected, full refund of 50
    push(K_ERR, 0); push(K_COIN, 4);
    select(50, 3);
    wait_idle("t2");

    // Cancel beats sel_valid: refund 185 = 100+50+25+10, straight to CHANGE
    push(K_COIN, 5); push(K_COIN, 4); push(K_COIN, 3); push(K_COIN, 2);
    drive_edge();
    credit = 9'd185; cancel = 1'b1; bus.sel_valid = 1'b1; bus.sel_item = 3'd2;
    drive_edge();
    credit = '0; cancel = 1'b0; bus.sel_valid = 1'b0;
    @(negedge clk);
    chk("t3_first_coin_valid", bus.coin_valid, 1);
    chk("t3_first_coin_code", bus.coin_code, 5);
    wait_idle("t3");

    // Credit 75, item 0: one 25 coin held through a 5-cycle stall
    push(K_VEND, 0); push(K_COIN, 3);
    drive_edge();
    bus.coin_ready = 1'b0;
    select(75, 0);
    begin
      int cnt = 0;
      @(negedge clk);
      while (!bus.coin_valid && cnt < 20) begin
        @(negedge clk);
        cnt++;
      end
      chk("t4_coin_offered", bus.coin_valid, 1);
      for (int i = 0; i < 5; i++) begin
        @(negedge clk);
        chk("t4_stall_valid", bus.coin_valid, 1);
        chk("t4_stall_code", bus.coin_code, 3);
      end
    end
    drive_edge();
    bus.coin_ready = 1'b1;
    wait_idle("t4");

    // Exact payment: vend only, no change
    push(K_VEND, 0);
    select(50, 0);
    wait_idle("t5");

    // Item 7 is not for sale: rejected, refund 100
    push(K_ERR, 0); push(K_COIN, 5);
    select(100, 7);
    wait_idle("t6");

    // 68 - 65 leaves 3 cents: vend then change_short
    push(K_VEND, 1); push(K_SHORT, 0);
    select(68, 1);
    wait_idle("t7");

    // Cancel with zero credit is ignored
    drive_edge();
    credit = '0; cancel = 1'b1;
    drive_edge();
    cancel = 1'b0;
    @(negedge clk);
    chk("t8_cancel_zero_busy", busy, 0);
    chk("t8_cancel_zero_coin", bus.coin_valid, 0);

    // Reset during CHANGE abandons the coin handshake
    drive_edge();
    bus.coin_ready = 1'b0;
    credit = 9'd185; cancel = 1'b1;
    drive_edge();
    credit = '0; cancel = 1'b0;
    @(negedge clk);
    chk("t9_in_change", bus.coin_valid, 1);
    drive_edge();
    reset = 1'b1;
    @(negedge clk);
    chk("t9_rst_sel_ready", bus.sel_ready, 1);
    chk("t9_rst_coin_valid", bus.coin_valid, 0);
    chk("t9_rst_busy", busy, 0);
    drive_edge();
    reset = 1'b0;
    bus.coin_ready = 1'b1;

`ifdef VEND_CHANGE_INVENTORY_EN
    // Counts reset to 0 by the reset above; load 25:1, 5:2, others 0.
    drive_edge();
    inv_load = 1'b1; inv_code = 3'd3; inv_count = 8'd1;
    drive_edge();
    inv_code = 3'd1; inv_count = 8'd2;
    drive_edge();
    inv_load = 1'b0;
    // 50 owed: 25, 5, 5, then 15 left with no usable coin
    push(K_VEND, 0); push(K_COIN, 3); push(K_COIN, 1); push(K_COIN, 1); push(K_SHORT, 0);
    select(100, 0);
    wait_idle("t10");
    chk("t10_inv25_empty", int'(dut.inv_cnt[2]), 0);
`endif

    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule
